adr_pipe_buf: RTL
=================

# adr_pipe_buf

Parametrised elastic pipeline register for inter-stage holding registers (address, data, instruction) in the multicycle datapath. It is the handshaked successor of the plain per-clock holding register. It holds up to DEPTH words of WIDTH bits in arrival order, adds valid/ready flow control and a synchronous flush, and always presents the oldest held word on a registered output.

## Interface
- WIDTH, 32, data word width in bits (1..64)
- DEPTH, 2, number of entries (2..16, power of two)
- CNTW, $clog2(DEPTH+1), width of the occupancy count
- CLK  input  1  rising-edge clock, single clock domain
- RST  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all held words
- inValid  input  1  producer offers dataIn this cycle
- inReady  output  1  buffer accepts a word this cycle
- dataIn  input  WIDTH  word from the producing stage
- outValid  output  1  dataOut holds a valid word
- outReady  input  1  consumer takes dataOut this cycle
- dataOut  output  WIDTH  oldest held word (registered)
- count  output  CNTW  number of words currently held

## Operation
- Storage is a circular array of DEPTH entries with a write pointer, a read pointer and a count. Pointers wrap modulo DEPTH.
- push = inValid & inReady. pop = outValid & outReady. flush takes priority over both.
- inReady = (count != DEPTH). It depends only on registered state, so there is no combinational path from outReady to inReady.
- outValid = (count != 0). dataOut always shows the entry at the read pointer. dataOut comes from a register, not from a mux fed by dataIn.
- Per-cycle count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing
  - neither: unchanged
- Full (count = DEPTH): inReady = 0. An offered word is not taken even if a pop occurs in the same cycle. There is no pass-through when full.
- Empty (count = 0): outValid = 0 and dataOut holds its last value. outReady is ignored.
- When outValid = 0, dataOut is don't-care for consumers. The bench must still check that it holds steady.
- flush = 1 at a rising edge: count, pointers and outValid clear, and inValid is ignored in that cycle. dataOut contents are not required to change.
- RST asserted at any time, including mid-transfer: all state clears immediately, independent of CLK. All held words are lost.
- Arithmetic: pointer increments are modulo DEPTH with no overflow flag. count never exceeds DEPTH and never underflows, because push and pop are gated by the ready/valid terms.

## Timing
- Reset values:
  - inReady = 1
  - outValid = 0
  - count = 0
  - dataOut = 0
  - pointers = 0
- Latency: a word pushed at edge N appears on dataOut with outValid = 1 after edge N, i.e. in cycle N+1. This matches the one-cycle delay of the plain holding register.
- Throughput: one word per cycle sustained, with push and pop in the same cycle when 0 < count < DEPTH.
- A pop at edge N presents the next word on dataOut after edge N. If none remains, outValid drops after edge N.
- Outputs change only on the CLK rising edge or on RST assertion.
- RST release is sampled synchronously. The first push is possible at the first rising edge after deassertion.
- Handshake rules:
  - A producer holding inValid = 1 keeps dataIn stable until inReady = 1.
  - The buffer never drops a word it has accepted, except on flush or RST.

## Test plan
- Reset and single transfer: RST pulse mid-cycle forces count = 0, outValid = 0, dataOut = 0 at once. Then push 0x0000_1234 with outReady = 0 → cycle after: outValid = 1, dataOut = 0x0000_1234, count = 1.
- Fill to full (DEPTH = 2): push 0xA, 0xB with outReady = 0 → count = 2, inReady = 0. Offer 0xC together with one pop → 0xC is rejected, dataOut = 0xB, count = 1.
- Streaming with wrap: push 0x1..0x20 with outReady = 1 every cycle → dataOut shows 0x1..0x20 in order, one per cycle, one cycle after each push. count stays at 1, and the pointers wrap several times.
- Backpressure order: alternate outReady 1/0 while pushing 0x100..0x10F with a random inValid pattern → outputs appear in order with no loss or duplication, and count ≤ DEPTH at all times.
- Flush with activity: count = 2, then flush = 1 with inValid = 1 and dataIn = 0x55 → next cycle count = 0, outValid = 0, and 0x55 is never output.
- Async reset mid-stream: RST asserted between edges while count = 2 → outValid = 0, count = 0, inReady = 1 immediately, before the next edge.

Source files
------------

// File: rtl/adr_pipe_buf.sv
// Elastic holding register: DEPTH-entry in-order buffer with valid/ready handshake and synchronous flush.
// dataOut is registered and always shows the oldest word; a word pushed at edge N is visible in cycle N+1.
module adr_pipe_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOut,
    output logic [CNTW-1:0]  count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [CNTW-1:0]  count_next;
    logic [WIDTH-1:0] head_next;
    logic             push;
    logic             pop;

    // Both handshake terms decode registered count only, so outReady never reaches inReady.
    assign inReady  = (count != CNTW'(DEPTH));
    assign outValid = (count != '0);
    assign push     = inValid & inReady;
    assign pop      = outValid & outReady;

    always_comb begin
        rd_next    = pop ? rd_ptr + PW'(1) : rd_ptr;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
        // The new head is the incoming word only when it lands in the slot the read pointer moves to.
        head_next = (push && (wr_ptr == rd_next)) ? dataIn : mem[rd_next];
    end

    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dataOut <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            // When the buffer drains, dataOut keeps its last word.
            if (count_next != '0) begin
                dataOut <= head_next;
            end
        end
    end
endmodule
